// File: rtl/wide_add_seq_if.sv
// Operation request/result bundle for wide_add_seq.
// master = requester/consumer side, slave = the adder.
// Widths follow NSLICE so both sides must use the same value.
interface wide_add_seq_if #(
  parameter int NSLICE = 4
);
  localparam int W = 5 * NSLICE;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         busy;

  modport master (
    output start_valid, A, B, Cin, sub, res_ready,
    input  start_ready, res_valid, S, Cout, busy
  );

  modport slave (
    input  start_valid, A, B, Cin, sub, res_ready,
    output start_ready, res_valid, S, Cout, busy
  );
endinterface

// File: rtl/wide_add_seq.sv
// Sequential W-bit adder/subtractor reusing one 5-bit ripple slice per cycle.
// Latency: result valid NSLICE edges after the accept edge.
// Backpressure: result held in DONE until res_ready; no new accept until then.
module wide_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic           clk,
  input  logic           reset,
  wide_add_seq_if.slave  bus
);
  localparam int W  = 5 * NSLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  s_q;
  logic [W-1:0]  s_nxt;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          cout_q;
  logic          vld_q;
  logic          rdy_q;
  logic          busy_q;

  // Operands shift right one slice per ADD cycle, so the active slice is
  // always the low 5 bits; the finished slice enters S from the top, and
  // after NSLICE shifts slice cnt lands at S[5*cnt +: 5].
  logic [4:0] sl_a;
  logic [4:0] sl_b;
  logic [4:0] sl_s;
  logic [5:0] sl_c;
  logic       sl_co;

  assign sl_a  = opa[4:0];
  assign sl_b  = opb[4:0];
  assign sl_co = sl_c[5];

  // The single 5-bit slice: ripple of 1-bit full adders fed by the carry register.
  always_comb begin
    sl_s    = '0;
    sl_c    = '0;
    sl_c[0] = carry;
    for (int i = 0; i < 5; i++) begin
      sl_s[i]   = sl_a[i] ^ sl_b[i] ^ sl_c[i];
      sl_c[i+1] = (sl_a[i] & sl_b[i]) | (sl_c[i] & (sl_a[i] ^ sl_b[i]));
    end
  end

  // Next S: shift down one slice and drop the new slice into the top.
  always_comb begin
    s_nxt           = s_q >> 5;
    s_nxt[W-1 -: 5] = sl_s;
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            opa    <= bus.A;
            // Subtract as A + ~B + 1.
            opb    <= bus.sub ? ~bus.B : bus.B;
            carry  <= bus.sub ? 1'b1 : bus.Cin;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          s_q   <= s_nxt;
          carry <= sl_co;
          opa   <= opa >> 5;
          opb   <= opb >> 5;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NSLICE - 1)) begin
            cout_q <= sl_co;
            vld_q  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = rdy_q;
  assign bus.res_valid   = vld_q;
  assign bus.S           = s_q;
  assign bus.Cout        = cout_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed cases with literal results plus random
// traffic, all checked against a transaction-level model of the adder.
module tb_wide_add_seq;
  localparam int NSLICE = 4;
  localparam int W      = 5 * NSLICE;

  logic clk;
  logic reset;

  wide_add_seq_if #(.NSLICE(NSLICE)) bus ();

  wide_add_seq #(.NSLICE(NSLICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted operation yields its arithmetic result
  // NSLICE edges later and holds it until the consumer takes it.
  logic         m_ready = 1'b1;
  logic         m_vld   = 1'b0;
  logic         m_busy  = 1'b0;
  int           m_cd    = 0;
  logic [W-1:0] m_s     = '0;
  logic         m_c     = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 1'b1;
      m_vld   = 1'b0;
      m_busy  = 1'b0;
      m_cd    = 0;
    end else if (m_ready) begin
      if (bus.start_valid) begin
        if (bus.sub) begin
          m_s = bus.A - bus.B;
          m_c = (bus.A >= bus.B);
        end else begin
          {m_c, m_s} = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, bus.Cin};
        end
        m_ready = 1'b0;
        m_busy  = 1'b1;
        m_cd    = NSLICE;
      end
    end else if (!m_vld) begin
      m_cd--;
      if (m_cd == 0) m_vld = 1'b1;
    end else if (bus.res_ready) begin
      m_vld   = 1'b0;
      m_busy  = 1'b0;
      m_ready = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("start_ready", 32'(bus.start_ready), 32'(m_ready));
    chk("res_valid",   32'(bus.res_valid),   32'(m_vld));
    chk("busy",        32'(bus.busy),        32'(m_busy));
    if (m_vld) begin
      chk("S",    32'(bus.S),    32'(m_s));
      chk("Cout", 32'(bus.Cout), 32'(m_c));
    end
  end

  // One operation with literal expectations; hold = cycles of backpressure.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sb, input logic [W-1:0] es, input logic ec, input int hold);
    int k;
    chk("accept_ready", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.sub = sb; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    // Operands change right after the accept edge and must not matter.
    bus.start_valid = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom);
    bus.Cin = 1'($urandom); bus.sub = 1'($urandom);
    k = 0;
    while (!bus.res_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(NSLICE));
    chk("lit_S", 32'(bus.S), 32'(es));
    chk("lit_Cout", 32'(bus.Cout), 32'(ec));
    chk("model_S", 32'(m_s), 32'(es));
    chk("model_Cout", 32'(m_c), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      bus.A = W'($urandom); bus.B = W'($urandom);
      bus.start_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_S", 32'(bus.S), 32'(es));
      chk("hold_Cout", 32'(bus.Cout), 32'(ec));
      chk("hold_ready", 32'(bus.start_ready), 32'd0);
    end
    // Handshake edge with start_valid high: must not start a new operation.
    bus.res_ready   = 1'b1;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.res_ready   = 1'b0;
    bus.start_valid = 1'b0;
    chk("post_valid", 32'(bus.res_valid), 32'd0);
    chk("post_ready", 32'(bus.start_ready), 32'd1);
    chk("post_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int last, nres;
    reset = 1'b1;
    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_S",     32'(bus.S), 32'd0);
    chk("rst_Cout",  32'(bus.Cout), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic cases; accept happens on the first edge after release.
    do_op(20'h00001, 20'h00001, 1'b0, 1'b0, 20'h00002, 1'b0, 0);
    do_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 0);
    do_op(20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 0);
    do_op(20'h00007, 20'h00005, 1'b1, 1'b1, 20'h00002, 1'b1, 10);
    do_op(20'h12345, 20'h0ABCD, 1'b1, 1'b0, 20'h1CF13, 1'b0, 2);

    // Reset in the middle of an operation (cnt = 2).
    bus.start_valid = 1'b1;
    bus.A = 20'hAAAAA; bus.B = 20'h55555; bus.sub = 1'b0; bus.Cin = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.start_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy), 32'd0);
    chk("mid_rst_S",     32'(bus.S), 32'd0);
    chk("mid_rst_Cout",  32'(bus.Cout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(20'h0F0F0, 20'h00F10, 1'b1, 1'b0, 20'h10001, 1'b0, 0);

    // Back-to-back: always requesting, always consuming.
    bus.start_valid = 1'b1;
    bus.res_ready   = 1'b1;
    last = -1;
    nres = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        if (last >= 0) chk("b2b_spacing", 32'(c - last), 32'(NSLICE + 2));
        last = c;
        nres++;
      end
      bus.A = W'($urandom); bus.B = W'($urandom);
      bus.Cin = 1'($urandom); bus.sub = 1'($urandom);
    end
    chk("b2b_count_ok", 32'(nres >= 30), 32'd1);

    // Random traffic with random request/consume timing.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      bus.start_valid = 1'($urandom);
      bus.res_ready   = ($urandom_range(0, 2) != 0);
      bus.A = W'($urandom); bus.B = W'($urandom);
      bus.Cin = 1'($urandom); bus.sub = 1'($urandom);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    repeat (NSLICE + 3) @(posedge clk);
    #1;
    chk("drain_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter: NSLICE, default 4, number of 5-bit slices; operand width W = 5*NSLICE (20 by default).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  block can accept an operation.
REQ-006 A  input  W  operand A, sampled only on the accept edge.
REQ-007 B  input  W  operand B, sampled only on the accept edge.
REQ-008 Cin  input  1  carry-in for add, sampled on the accept edge.
REQ-009 sub  input  1  1 = compute A-B, 0 = compute A+B+Cin; sampled on the accept edge.
REQ-010 res_valid  output  1  result S/Cout valid.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 S  output  W  registered sum or difference.
REQ-013 Cout  output  1  carry out of the top slice; for sub, 1 = no borrow.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL contain exactly one 5-bit full-adder slice (ripple of 1-bit full adders, with carry-in) and reuse it once per cycle to add W-bit operands, least significant slice first.
REQ-016 FSM states: IDLE, ADD, DONE.
REQ-017 IDLE: start_ready=1; on start_valid=1 at a clock edge (accept edge):
  - latch A into opa and (sub ? ~B : B) into opb;
  - set carry register to (sub ? 1 : Cin);
  - clear slice counter cnt to 0;
  - go to ADD.
REQ-018 ADD, each edge:
  - slice cnt of opa/opb plus carry register is written to S[5*cnt+4:5*cnt];
  - carry register takes the slice carry-out;
  - cnt increments.
REQ-019 When cnt = NSLICE-1, the edge that writes the last slice SHALL also load Cout with the final carry and move the FSM to DONE.
REQ-020 Latency: res_valid SHALL rise exactly NSLICE edges after the accept edge (4 by default).
REQ-021 DONE: res_valid=1; S and Cout SHALL hold stable until the edge where res_ready=1; that edge returns the FSM to IDLE and clears res_valid.
REQ-022 start_ready SHALL be 0 in ADD and DONE.
  - start_valid is ignored there; no queuing.
  - An accept is possible no earlier than the edge after the result handshake.
REQ-023 Changes on A, B, Cin or sub after the accept edge SHALL NOT affect the result.
REQ-024 S bits of slices not yet written in ADD are don't-care; only S/Cout with res_valid=1 are defined.
REQ-025 Arithmetic is modulo 2^W; overflow is reported only via Cout, with no saturation.

Reset
REQ-026 While reset=1, asynchronously and regardless of state:
  - FSM=IDLE, cnt=0, carry=0;
  - opa=opb=0, S=0, Cout=0;
  - res_valid=0, busy=0, start_ready=1.
REQ-027 Reset asserted mid-ADD or in DONE SHALL discard the operation; no res_valid pulse follows.
REQ-028 The first accept after reset release SHALL be possible at the first rising edge with reset=0.

Verification
REQ-029 A=0x00001, B=0x00001, Cin=0, sub=0 -> res_valid 4 edges after accept; S=0x00002, Cout=0.
REQ-030 A=0xFFFFF, B=0x00001, Cin=0, sub=0 -> carry ripples through all slices; S=0x00000, Cout=1.
REQ-031 A=0x00005, B=0x00007, sub=1 -> S=0xFFFFE, Cout=0 (borrow); A=0x00007, B=0x00005, sub=1 -> S=0x00002, Cout=1.
REQ-032 Backpressure: hold res_ready=0 for 10 cycles after res_valid, toggle A/B/start_valid throughout -> res_valid, S and Cout stay constant, start_ready=0; res_ready=1 -> IDLE on the next edge.
REQ-033 Assert reset at cnt=2 of an operation -> all outputs reach reset values immediately; after release, A=0x0F0F0, B=0x00F10, Cin=1 -> S=0x10001, Cout=0.
REQ-034 Back-to-back: keep start_valid=1 and res_ready=1 with new operands each accept -> one result per NSLICE+2 cycles, each result correct, none dropped or duplicated.
